// File: rtl/spi_bridge_pkg.sv
// Shared types for the AXI-Stream SPI register bridge.
//   bridge_state_e : frame sequencer states (IDLE, SEND, RECV, RESP)
//   RW_READ/RW_WRITE : value of the header MSB selecting read or write
package spi_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    RECV = 2'd2,
    RESP = 2'd3
  } bridge_state_e;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

endpackage

// File: rtl/axis_if.sv
// Minimal AXI-Stream byte interface used between the bridge and the SPI master.
//   tdata/tvalid/tlast : source -> sink
//   tready             : sink -> source
interface axis_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/spi_bridge_watchdog.sv
// Response watchdog for the SPI register bridge.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_state        : current bridge state
//   o_expired      : high in the cycle the count in SEND/RECV reaches TIMEOUT-1
// The count restarts on every state change; it advances only in SEND or RECV.
module spi_bridge_watchdog
  import spi_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  bridge_state_e i_state,
  output logic          o_expired
);

  localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

  bridge_state_e r_prev_state;
  logic [CW-1:0] r_count;
  logic [CW-1:0] w_count;
  logic          w_active;

  assign w_active  = (i_state == SEND) || (i_state == RECV);
  // A fresh state sees count 0 in its first cycle, so expiry lands exactly
  // TIMEOUT cycles after entry.
  assign w_count   = (i_state != r_prev_state) ? '0 : r_count;
  assign o_expired = w_active && (w_count == LIMIT);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_prev_state <= IDLE;
      r_count      <= '0;
    end else begin
      r_prev_state <= i_state;
      r_count      <= w_active ? (w_count + 1'b1) : w_count;
    end
  end

endmodule

// File: rtl/axis_spi_reg_bridge.sv
// Register-access front end for the AXI-Stream SPI master.
// Serialises one read/write command into a frame {rw,reg} + REG_BYTES data
// bytes on m_axis (tlast on the final byte), collects the echoed MISO bytes
// from s_axis and returns them as one response. One byte in flight at a time.
// Ports:
//   clk_i, arstn_i           : clock, asynchronous active-low reset
//   cmd_*                    : command channel (ready only in IDLE)
//   rsp_*                    : response channel (data/err stable until ready)
//   spi_addr_o               : chip-select index latched at command accept
//   m_axis / s_axis          : TX to / RX from the SPI master
// Optional macro SPI_BRIDGE_TIMEOUT_EN: response watchdog sets rsp_err_o on
// expiry; without it rsp_err_o is 0 and the bridge waits indefinitely.
module axis_spi_reg_bridge
  import spi_bridge_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 7,
  parameter int unsigned REG_BYTES  = 2,
  parameter int unsigned SLAVE_NUM  = 2,
  parameter int unsigned TIMEOUT    = 1024
) (
  input  logic                            clk_i,
  input  logic                            arstn_i,
  input  logic                            cmd_valid_i,
  output logic                            cmd_ready_o,
  input  logic                            cmd_rw_i,
  input  logic [$clog2(SLAVE_NUM)-1:0]    cmd_slave_i,
  input  logic [ADDR_WIDTH-1:0]           cmd_reg_i,
  input  logic [REG_BYTES*DATA_WIDTH-1:0] cmd_wdata_i,
  output logic                            rsp_valid_o,
  input  logic                            rsp_ready_i,
  output logic [REG_BYTES*DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                            rsp_err_o,
  output logic [$clog2(SLAVE_NUM)-1:0]    spi_addr_o,
  axis_if.master                          m_axis,
  axis_if.slave                           s_axis
);

  localparam int unsigned PW   = REG_BYTES * DATA_WIDTH;
  localparam int unsigned CNTW = $clog2(REG_BYTES + 1);
  localparam logic [CNTW-1:0] CNT_LOAD = CNTW'(REG_BYTES);

  bridge_state_e                  r_state;
  logic                           r_cmd_ready;
  logic                           r_rsp_valid;
  logic                           r_rsp_err;
  logic                           r_tx_valid;
  logic                           r_tx_last;
  logic [DATA_WIDTH-1:0]          r_tx_data;
  logic                           r_rx_ready;
  logic [CNTW-1:0]                r_cnt;
  logic [PW-1:0]                  r_payload;
  logic [PW-1:0]                  r_rx;
  logic [$clog2(SLAVE_NUM)-1:0]   r_spi_addr;
  logic                           w_timeout;
  logic                           w_unused;

`ifdef SPI_BRIDGE_TIMEOUT_EN
  spi_bridge_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .i_clk     (clk_i),
    .i_rst_n   (arstn_i),
    .i_state   (r_state),
    .o_expired (w_timeout)
  );
  assign w_unused = s_axis.tlast;
`else
  assign w_timeout = 1'b0;
  assign w_unused  = s_axis.tlast & (TIMEOUT != 0);
`endif

  assign cmd_ready_o   = r_cmd_ready;
  assign rsp_valid_o   = r_rsp_valid;
  assign rsp_rdata_o   = r_rx;
  assign rsp_err_o     = r_rsp_err;
  assign spi_addr_o    = r_spi_addr;
  assign m_axis.tvalid = r_tx_valid;
  assign m_axis.tlast  = r_tx_last;
  assign m_axis.tdata  = r_tx_data;
  assign s_axis.tready = r_rx_ready;

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      r_state     <= IDLE;
      r_cmd_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_tx_valid  <= 1'b0;
      r_tx_last   <= 1'b0;
      r_tx_data   <= '0;
      r_rx_ready  <= 1'b0;
      r_cnt       <= '0;
      r_payload   <= '0;
      r_rx        <= '0;
      r_spi_addr  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (cmd_valid_i && r_cmd_ready) begin
            r_cmd_ready <= 1'b0;
            r_tx_valid  <= 1'b1;
            r_tx_last   <= 1'b0;
            r_tx_data   <= {cmd_rw_i, cmd_reg_i};
            r_payload   <= (cmd_rw_i == RW_READ) ? '0 : cmd_wdata_i;
            r_cnt       <= CNT_LOAD;
            r_rx        <= '0;
            r_rsp_err   <= 1'b0;
            r_spi_addr  <= cmd_slave_i;
            r_state     <= SEND;
          end
        end
        SEND: begin
          if (w_timeout) begin
            r_tx_valid  <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b1;
            r_state     <= RESP;
          end else if (m_axis.tready) begin
            r_tx_valid <= 1'b0;
            r_rx_ready <= 1'b1;
            r_state    <= RECV;
          end
        end
        RECV: begin
          if (s_axis.tvalid) begin
            // Header echo carries no register data.
            if (r_cnt != CNT_LOAD) begin
              r_rx <= PW'({r_rx, s_axis.tdata});
            end
            r_rx_ready <= 1'b0;
            if (r_cnt == '0) begin
              r_rsp_valid <= 1'b1;
              r_state     <= RESP;
            end else begin
              r_cnt      <= r_cnt - 1'b1;
              r_tx_data  <= r_payload[PW-1 -: DATA_WIDTH];
              r_payload  <= r_payload << DATA_WIDTH;
              r_tx_last  <= (r_cnt == CNTW'(1));
              r_tx_valid <= 1'b1;
              r_state    <= SEND;
            end
          end else if (w_timeout) begin
            r_rx_ready  <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b1;
            r_state     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready_i) begin
            r_rsp_valid <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_spi_reg_bridge.sv
module tb_axis_spi_reg_bridge;

  logic        clk = 1'b0;
  logic        arstn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_rw;
  logic [0:0]  cmd_slave;
  logic [6:0]  cmd_reg;
  logic [15:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_rdata;
  logic        rsp_err;
  logic [0:0]  spi_addr;

  int checks = 0;
  int failures = 0;

  axis_if #(.DATA_WIDTH(8)) tx_if ();
  axis_if #(.DATA_WIDTH(8)) rx_if ();

  axis_spi_reg_bridge #(
    .DATA_WIDTH (8),
    .ADDR_WIDTH (7),
    .REG_BYTES  (2),
    .SLAVE_NUM  (2),
    .TIMEOUT    (64)
  ) dut (
    .clk_i       (clk),
    .arstn_i     (arstn),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_rw_i    (cmd_rw),
    .cmd_slave_i (cmd_slave),
    .cmd_reg_i   (cmd_reg),
    .cmd_wdata_i (cmd_wdata),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_rdata_o (rsp_rdata),
    .rsp_err_o   (rsp_err),
    .spi_addr_o  (spi_addr),
    .m_axis      (tx_if),
    .s_axis      (rx_if)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL global_timeout observed=hang expected=finish");
    $fatal(1, "simulation time limit");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic accept(input logic rw, input logic [0:0] slv, input logic [6:0] rg,
                        input logic [15:0] wd);
    cmd_valid = 1'b1; cmd_rw = rw; cmd_slave = slv; cmd_reg = rg; cmd_wdata = wd;
    check("cmd_ready_idle", cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("tx_valid_n_plus_1", tx_if.tvalid, 1);
  endtask

  task automatic run_frame(input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2,
                           input logic [7:0] m1, input logic [7:0] m2,
                           input int stall_idx, input int stall_n, input logic [0:0] slv);
    logic [7:0] exp_b [3];
    logic [7:0] mis_b [3];
    int n;
    exp_b[0] = e0; exp_b[1] = e1; exp_b[2] = e2;
    mis_b[0] = 8'hEE; mis_b[1] = m1; mis_b[2] = m2;
    for (int i = 0; i < 3; i++) begin
      n = 0;
      while (tx_if.tvalid !== 1'b1 && n < 50) begin
        @(negedge clk);
        n++;
      end
      check("tx_valid", tx_if.tvalid, 1);
      check("tx_data", tx_if.tdata, exp_b[i]);
      check("tx_last", tx_if.tlast, (i == 2) ? 1 : 0);
      check("spi_addr", spi_addr, slv);
      if (i == stall_idx) begin
        for (int k = 0; k < stall_n; k++) begin
          tx_if.tready = 1'b0;
          @(negedge clk);
          check("stall_valid", tx_if.tvalid, 1);
          check("stall_data", tx_if.tdata, exp_b[i]);
        end
      end
      tx_if.tready = 1'b1;
      @(negedge clk);
      tx_if.tready = 1'b0;
      check("tx_valid_low_in_recv", tx_if.tvalid, 0);
      check("rx_ready", rx_if.tready, 1);
      rx_if.tvalid = 1'b1;
      rx_if.tdata  = mis_b[i];
      rx_if.tlast  = (i == 2);
      @(negedge clk);
      rx_if.tvalid = 1'b0;
      rx_if.tlast  = 1'b0;
    end
    check("rsp_valid", rsp_valid, 1);
    check("rsp_err", rsp_err, 0);
  endtask

  task automatic finish_rsp(input logic [15:0] exp_rd);
    check("rsp_rdata", rsp_rdata, exp_rd);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("rsp_valid_drop", rsp_valid, 0);
    check("cmd_ready_back", cmd_ready, 1);
  endtask

  initial begin
    arstn = 1'b0;
    cmd_valid = 1'b0; cmd_rw = 1'b0; cmd_slave = '0; cmd_reg = '0; cmd_wdata = '0;
    rsp_ready = 1'b0;
    tx_if.tready = 1'b0;
    rx_if.tvalid = 1'b0; rx_if.tdata = '0; rx_if.tlast = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_tx_valid", tx_if.tvalid, 0);
    check("rst_tx_last", tx_if.tlast, 0);
    check("rst_tx_data", tx_if.tdata, 0);
    check("rst_spi_addr", spi_addr, 0);
    check("rst_rx_ready", rx_if.tready, 0);
    arstn = 1'b1;
    @(negedge clk);

    // Write 0x12 <= 0xBEEF on slave 1; MISO during write still returned.
    accept(1'b0, 1'b1, 7'h12, 16'hBEEF);
    run_frame(8'h12, 8'hBE, 8'hEF, 8'h11, 8'h22, -1, 0, 1'b1);
    finish_rsp(16'h1122);

    // Read 0x05 on slave 0.
    accept(1'b1, 1'b0, 7'h05, 16'hFFFF);
    run_frame(8'h85, 8'h00, 8'h00, 8'hA5, 8'h3C, -1, 0, 1'b0);
    finish_rsp(16'hA53C);

    // TX backpressure for 20 cycles on byte 1.
    accept(1'b0, 1'b1, 7'h7F, 16'h0102);
    run_frame(8'h7F, 8'h01, 8'h02, 8'h5A, 8'h00, 1, 20, 1'b1);
    finish_rsp(16'h5A00);

    // Response held for 10 cycles while a second command waits.
    accept(1'b0, 1'b0, 7'h33, 16'h5AA5);
    run_frame(8'h33, 8'h5A, 8'hA5, 8'h01, 8'h02, -1, 0, 1'b0);
    cmd_valid = 1'b1; cmd_rw = 1'b1; cmd_slave = 1'b1; cmd_reg = 7'h10; cmd_wdata = 16'h0;
    for (int k = 0; k < 10; k++) begin
      check("hold_rsp_valid", rsp_valid, 1);
      check("hold_rsp_rdata", rsp_rdata, 16'h0102);
      check("blocked_cmd_ready", cmd_ready, 0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("rsp_valid_after_hs", rsp_valid, 0);
    check("cmd_ready_after_hs", cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("second_cmd_tx_valid", tx_if.tvalid, 1);
    run_frame(8'h90, 8'h00, 8'h00, 8'hC3, 8'h3C, -1, 0, 1'b1);
    finish_rsp(16'hC33C);

    // Reset pulse while byte 1 is on the bus.
    accept(1'b0, 1'b1, 7'h01, 16'h1234);
    tx_if.tready = 1'b1;
    @(negedge clk);
    tx_if.tready = 1'b0;
    rx_if.tvalid = 1'b1; rx_if.tdata = 8'h99;
    @(negedge clk);
    rx_if.tvalid = 1'b0;
    check("byte1_before_reset", tx_if.tdata, 8'h12);
    arstn = 1'b0;
    #1;
    check("mid_rst_cmd_ready", cmd_ready, 1);
    check("mid_rst_rsp_valid", rsp_valid, 0);
    check("mid_rst_rsp_err", rsp_err, 0);
    check("mid_rst_tx_valid", tx_if.tvalid, 0);
    check("mid_rst_tx_data", tx_if.tdata, 0);
    check("mid_rst_tx_last", tx_if.tlast, 0);
    check("mid_rst_spi_addr", spi_addr, 0);
    check("mid_rst_rx_ready", rx_if.tready, 0);
    @(negedge clk);
    arstn = 1'b1;
    @(negedge clk);
    accept(1'b1, 1'b0, 7'h7E, 16'h0000);
    run_frame(8'hFE, 8'h00, 8'h00, 8'hDE, 8'hAD, -1, 0, 1'b0);
    finish_rsp(16'hDEAD);

`ifdef SPI_BRIDGE_TIMEOUT_EN
    // No echo ever arrives: error response 64 cycles after entering RECV.
    accept(1'b1, 1'b1, 7'h44, 16'h0000);
    tx_if.tready = 1'b1;
    @(negedge clk);
    tx_if.tready = 1'b0;
    check("to_in_recv", rx_if.tready, 1);
    for (int k = 1; k < 64; k++) begin
      @(negedge clk);
      check("to_not_yet", rsp_valid, 0);
    end
    @(negedge clk);
    check("to_rsp_valid", rsp_valid, 1);
    check("to_rsp_err", rsp_err, 1);
    check("to_rsp_rdata", rsp_rdata, 16'h0000);
    finish_rsp(16'h0000);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axis_spi_reg_bridge.md
# axis_spi_reg_bridge

Register-access front end for the AXI-Stream SPI master. It accepts one register read or write command and serialises it into an AXI-Stream byte frame: a header byte followed by `REG_BYTES` data bytes, with `tlast` on the final byte. It collects the same number of echoed MISO bytes from the SPI master's output stream and returns the assembled read data as a single response. It sits directly upstream and downstream of the SPI master: its `m_axis` feeds the master's `s_axis`, and it consumes the master's `m_axis`.

## Interface

**Parameters**
- `DATA_WIDTH`, 8: SPI word width; must match the SPI master.
- `ADDR_WIDTH`, 7: register address width; `ADDR_WIDTH + 1 == DATA_WIDTH`.
- `REG_BYTES`, 2: payload bytes per access, range 1..4.
- `SLAVE_NUM`, 2: number of chip selects on the master.
- `TIMEOUT`, 1024: response watchdog limit in `clk_i` cycles (used only with the macro).

**Ports**
- `clk_i` in 1: single clock.
- `arstn_i` in 1: asynchronous, active-low reset.
- `cmd_valid_i` in 1: command valid.
- `cmd_ready_o` out 1: command ready; high only in IDLE.
- `cmd_rw_i` in 1: 1 = read, 0 = write.
- `cmd_slave_i` in `$clog2(SLAVE_NUM)`: target slave.
- `cmd_reg_i` in `ADDR_WIDTH`: register address.
- `cmd_wdata_i` in `REG_BYTES*DATA_WIDTH`: write data, sent MSB byte first.
- `rsp_valid_o` out 1: response valid.
- `rsp_ready_i` in 1: response ready.
- `rsp_rdata_o` out `REG_BYTES*DATA_WIDTH`: read data; MISO bytes captured during a write are returned as well.
- `rsp_err_o` out 1: timeout flag; always 0 when the macro is absent.
- `spi_addr_o` out `$clog2(SLAVE_NUM)`: chip-select index into the master's `addr_i`.
- `m_axis` `axis_if.master`: TX bytes to the SPI master.
- `s_axis` `axis_if.slave`: RX bytes from the SPI master.

## Operation

**States**
- IDLE: waiting for a command.
- SEND: presenting a byte on `m_axis`.
- RECV: waiting for that byte's echo on `s_axis`.
- RESP: presenting the response.

**Command accept and frame layout**
- Handshake `cmd_valid_i & cmd_ready_o` in IDLE latches all command fields, loads the byte counter with `REG_BYTES`, and moves to SEND.
- Byte 0 is `{cmd_rw_i, cmd_reg_i}`.
- Bytes 1..`REG_BYTES`:
  - write: `cmd_wdata_i`, MSB byte first;
  - read: 0x00.
- `m_axis.tlast` = 1 only on byte `REG_BYTES`.

**Byte exchange**
- SEND: `m_axis.tvalid` = 1. On handshake, go to RECV.
- RECV: `s_axis.tready` = 1. On `s_axis` handshake:
  - echo of byte 0 is discarded;
  - echoes of later bytes are shifted into the read shift register from the LSB side;
  - if the byte counter is 0, go to RESP; otherwise decrement the counter and go to SEND.
- Strict lockstep: exactly one byte is in flight. This keeps CS asserted between bytes, because the SPI master returns to its idle state between bytes and would otherwise see no pending data.
- `s_axis.tready` = 0 outside RECV. `s_axis.tlast` is ignored.

**Response**
- RESP: `rsp_valid_o` = 1. Data and error outputs are stable until `rsp_ready_i`; on handshake, go to IDLE.

**Slave select**
- `spi_addr_o` is registered from `cmd_slave_i` at accept and held until the next accept.

**Reset values**
- `cmd_ready_o` = 1.
- `rsp_valid_o` = 0, `rsp_rdata_o` = 0, `rsp_err_o` = 0.
- `m_axis.tvalid` = 0, `m_axis.tlast` = 0, `m_axis.tdata` = 0.
- `spi_addr_o` = 0.
- State = IDLE.
- Reset asserted mid-frame returns to IDLE immediately; the SPI master must be reset by the same `arstn_i`.

## Timing

- Command accept at cycle N puts byte 0 on `m_axis.tvalid` at cycle N+1.
- After an RX handshake in cycle M, the next TX byte is valid at M+1.
- `rsp_valid_o` is asserted the cycle after the final RX handshake.
- A response can be accepted in the same cycle it becomes valid; `cmd_ready_o` rises on the following cycle.
- No new command is accepted while any state other than IDLE is active; there is no overlap between frames.

## Configuration

Macro: `SPI_BRIDGE_TIMEOUT_EN`.

**When defined**
- A watchdog counter clears on every state change and increments while the block is in SEND or RECV.
- When the counter reaches `TIMEOUT-1`:
  - abort to RESP with `rsp_err_o` = 1;
  - `rsp_rdata_o` holds the bytes captured so far.

**When undefined**
- The counter is not built; `rsp_err_o` is tied to 0.
- The block waits indefinitely for each byte.

## Structure

- Package `spi_bridge_pkg` holds:
  - the state enum `bridge_state_e` (IDLE, SEND, RECV, RESP);
  - the read/write header-bit constants `RW_READ` = 1'b1 and `RW_WRITE` = 1'b0.
- One sub-module, `spi_bridge_watchdog`: the timeout counter, instantiated only under the macro.

## Test plan

1. Write reg 0x12, data 0xBEEF, `REG_BYTES` = 2 → `m_axis` bytes 0x12, 0xBE, 0xEF; `tlast` only on 0xEF; one response with `rsp_err_o` = 0.
2. Read reg 0x05, slave model returns 0xA5, 0x3C → bytes sent 0x85, 0x00, 0x00; `rsp_rdata_o` = 0xA53C; `spi_addr_o` equals `cmd_slave_i` throughout.
3. `m_axis.tready` held low for 20 cycles, then released → `m_axis.tdata` and `tvalid` stay stable; frame completes correctly.
4. `rsp_ready_i` low for 10 cycles → `rsp_valid_o` and data held; a second command stays blocked (`cmd_ready_o` = 0) until the response handshake.
5. `arstn_i` pulsed during byte 1 → all outputs return to their reset values; the next command completes normally.
6. With `SPI_BRIDGE_TIMEOUT_EN`, `TIMEOUT` = 64, and `s_axis` never valid → `rsp_valid_o` with `rsp_err_o` = 1 exactly 64 cycles after entering RECV.
